l15_mem_responder: RTL

//  L1.5-side responder model for the Lagarto/Ariane wt_cache L15 interface.

---
 rtl/l15_mem_responder.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/l15_mem_responder.sv
// l15_mem_responder: L1.5-side responder model for the wt_cache L15 interface.
// Serves one LOAD / IFILL / STORE at a time from a private 64-bit-word SRAM and
// returns after LATENCY cycles, standing in for the OpenPiton L1.5/NoC.
// Optional build macro: L15_RSP_RAND_STALL_EN (LFSR-driven random ack/return stalls).
module l15_mem_responder #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned ADDR_W    = 40
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              l15_val_i,
  output logic              l15_req_ack_o,
  input  logic [4:0]        l15_rqtype_i,
  input  logic [2:0]        l15_size_i,
  input  logic              l15_nc_i,
  input  logic              l15_threadid_i,
  input  logic [ADDR_W-1:0] l15_address_i,
  input  logic [63:0]       l15_data_i,
  output logic              l15_rtrn_val_o,
  input  logic              l15_rtrn_ack_i,
  output logic [3:0]        l15_rtrn_type_o,
  output logic              l15_rtrn_threadid_o,
  output logic              l15_rtrn_nc_o,
  output logic [255:0]      l15_rtrn_data_o,
  output logic              err_o
);

  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned WORD_W = 64;
  localparam int unsigned LINE_W = 256;

  localparam logic [4:0] RQ_LOAD  = 5'h00;
  localparam logic [4:0] RQ_STORE = 5'h01;
  localparam logic [4:0] RQ_IMISS = 5'h10;

  localparam logic [3:0] RT_LOAD  = 4'h0;
  localparam logic [3:0] RT_IFILL = 4'h1;
  localparam logic [3:0] RT_STACK = 4'h4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         rqtype_q, rqtype_d;
  logic [IDX_W-1:0]   widx_q, widx_d;
  logic               tid_q, tid_d;
  logic               nc_q, nc_d;
  logic               err_q, err_d;
  logic               rtrn_val_q, rtrn_val_d;
  logic [3:0]         rtrn_type_q, rtrn_type_d;
  logic               rtrn_tid_q, rtrn_tid_d;
  logic               rtrn_nc_q, rtrn_nc_d;
  logic [LINE_W-1:0]  rtrn_data_q, rtrn_data_d;

  logic               req_ack;
  logic               ack_allow;
  logic               resp_hold;
  logic               load_resp;
  logic [IDX_W-1:0]   in_widx;
  logic [4:0]         cur_rqtype;
  logic [IDX_W-1:0]   cur_widx;
  logic               cur_tid;
  logic               cur_nc;
  logic [3:0]         rd_type;
  logic [LINE_W-1:0]  rd_data;
  logic [IDX_W-1:0]   line_base;
  logic [7:0]         st_be;
  logic               st_we;
  logic               unused_addr_bits;

  logic [WORD_W-1:0]  mem_q [MEM_WORDS];

  // Word index wraps modulo MEM_WORDS: upper address bits are don't-care.
  assign in_widx          = l15_address_i[IDX_W+2:3];
  assign unused_addr_bits = ^l15_address_i[ADDR_W-1:IDX_W+3];

`ifdef L15_RSP_RAND_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [4:0]  stall_q, stall_d;

  // LFSR x^16+x^14+x^13+x^11+1 free-runs; stall counter caps extra return delay at 16.
  always_comb begin : stall_next
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    stall_d = stall_q;
    if (req_ack) begin
      stall_d = '0;
    end else if ((state_q == S_WAIT) && (cnt_q <= CNT_W'(1)) && resp_hold) begin
      stall_d = stall_q + 5'd1;
    end
  end

  // LFSR and stall counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin : stall_regs
    if (!rst_ni) begin
      lfsr_q  <= 16'hACE1;
      stall_q <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      stall_q <= stall_d;
    end
  end

  assign ack_allow = lfsr_q[0];
  assign resp_hold = ~lfsr_q[1] && (stall_q < 5'd16);
`else
  assign ack_allow = 1'b1;
  assign resp_hold = 1'b0;
`endif

  // In IDLE the request comes straight off the port; afterwards from the capture regs.
  always_comb begin : cur_req_sel
    if (state_q == S_IDLE) begin
      cur_rqtype = l15_rqtype_i;
      cur_widx   = in_widx;
      cur_tid    = l15_threadid_i;
      cur_nc     = l15_nc_i;
    end else begin
      cur_rqtype = rqtype_q;
      cur_widx   = widx_q;
      cur_tid    = tid_q;
      cur_nc     = nc_q;
    end
  end

  // Return payload: 16B line for LOAD, 32B line for IMISS, zero otherwise.
  always_comb begin : resp_payload
    rd_type   = RT_LOAD;
    rd_data   = '0;
    line_base = '0;
    case (cur_rqtype)
      RQ_LOAD: begin
        line_base             = {cur_widx[IDX_W-1:1], 1'b0};
        rd_data[63:0]         = mem_q[line_base];
        rd_data[127:64]       = mem_q[line_base + IDX_W'(1)];
      end
      RQ_IMISS: begin
        rd_type   = RT_IFILL;
        line_base = {cur_widx[IDX_W-1:2], 2'b00};
        for (int i = 0; i < 4; i++) begin
          rd_data[WORD_W*i +: WORD_W] = mem_q[line_base + IDX_W'(i)];
        end
      end
      RQ_STORE: begin
        rd_type = RT_STACK;
      end
      default: begin
        rd_type = RT_LOAD;
      end
    endcase
  end

  // Store byte enables: naturally aligned, address bits below the size are ignored.
  always_comb begin : store_mask
    case (l15_size_i)
      3'd0:    st_be = 8'b0000_0001 << l15_address_i[2:0];
      3'd1:    st_be = 8'b0000_0011 << {l15_address_i[2:1], 1'b0};
      3'd2:    st_be = 8'b0000_1111 << {l15_address_i[2], 2'b00};
      default: st_be = 8'hFF;
    endcase
  end

  assign st_we = req_ack && (l15_rqtype_i == RQ_STORE);

  // FSM next state, request capture and registered return fields.
  always_comb begin : fsm_next
    state_d     = state_q;
    cnt_d       = cnt_q;
    rqtype_d    = rqtype_q;
    widx_d      = widx_q;
    tid_d       = tid_q;
    nc_d        = nc_q;
    err_d       = err_q;
    rtrn_val_d  = rtrn_val_q;
    rtrn_type_d = rtrn_type_q;
    rtrn_tid_d  = rtrn_tid_q;
    rtrn_nc_d   = rtrn_nc_q;
    rtrn_data_d = rtrn_data_q;
    req_ack     = 1'b0;
    load_resp   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (l15_val_i && ack_allow) begin
          req_ack  = 1'b1;
          rqtype_d = l15_rqtype_i;
          widx_d   = in_widx;
          tid_d    = l15_threadid_i;
          nc_d     = l15_nc_i;
          if ((l15_rqtype_i != RQ_LOAD) && (l15_rqtype_i != RQ_STORE) &&
              (l15_rqtype_i != RQ_IMISS)) begin
            err_d = 1'b1;
          end
          if (LATENCY <= 1) begin
            state_d   = S_RESP;
            load_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          if (!resp_hold) begin
            cnt_d     = '0;
            state_d   = S_RESP;
            load_resp = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (l15_rtrn_ack_i) begin
          state_d     = S_IDLE;
          rtrn_val_d  = 1'b0;
          rtrn_type_d = '0;
          rtrn_tid_d  = 1'b0;
          rtrn_nc_d   = 1'b0;
          rtrn_data_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_resp) begin
      rtrn_val_d  = 1'b1;
      rtrn_type_d = rd_type;
      rtrn_tid_d  = cur_tid;
      rtrn_nc_d   = cur_nc;
      rtrn_data_d = rd_data;
    end
  end

  // Control and output registers; reset drops any pending return.
  always_ff @(posedge clk_i or negedge rst_ni) begin : state_regs
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rqtype_q    <= '0;
      widx_q      <= '0;
      tid_q       <= 1'b0;
      nc_q        <= 1'b0;
      err_q       <= 1'b0;
      rtrn_val_q  <= 1'b0;
      rtrn_type_q <= '0;
      rtrn_tid_q  <= 1'b0;
      rtrn_nc_q   <= 1'b0;
      rtrn_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rqtype_q    <= rqtype_d;
      widx_q      <= widx_d;
      tid_q       <= tid_d;
      nc_q        <= nc_d;
      err_q       <= err_d;
      rtrn_val_q  <= rtrn_val_d;
      rtrn_type_q <= rtrn_type_d;
      rtrn_tid_q  <= rtrn_tid_d;
      rtrn_nc_q   <= rtrn_nc_d;
      rtrn_data_q <= rtrn_data_d;
    end
  end

  // Backing SRAM: stores commit on the accept edge; contents survive reset.
  always_ff @(posedge clk_i) begin : sram_write
    if (st_we) begin
      for (int b = 0; b < 8; b++) begin
        if (st_be[b]) begin
          mem_q[in_widx][8*b +: 8] <= l15_data_i[8*b +: 8];
        end
      end
    end
  end

  assign l15_req_ack_o       = req_ack;
  assign l15_rtrn_val_o      = rtrn_val_q;
  assign l15_rtrn_type_o     = rtrn_type_q;
  assign l15_rtrn_threadid_o = rtrn_tid_q;
  assign l15_rtrn_nc_o       = rtrn_nc_q;
  assign l15_rtrn_data_o     = rtrn_data_q;
  assign err_o               = err_q;

endmodule
